// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the multi-cycle divider.
package div_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    localparam logic              RstEnable         = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord          = 32'h0000_0000;
    localparam logic              DivResultReady    = 1'b1;
    localparam logic              DivResultNotReady = 1'b0;
    localparam logic              DivStart          = 1'b1;
    localparam logic              DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; returns {remainder, quotient}
// 34 cycles after an accepted start, or 2 cycles for a zero divisor.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             w_q, w_d;
    logic [RegBus-1:0]       dvd_q, dvd_d;
    logic [RegBus-1:0]       dvs_q, dvs_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    load_q, load_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [RegBus:0]         diff;
    logic [RegBus-1:0]       quot, rem;

    assign diff = {1'b0, w_q[63:32]} - {1'b0, dvs_q};
    assign quot = neg_quot_q ? -w_q[31:0]  : w_q[31:0];
    assign rem  = neg_rem_q  ? -w_q[64:33] : w_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        load_d     = load_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DivFree: begin
                // Operands are captured on the start edge; the divisor check and
                // working-register setup happen on the following edge.
                if (annul_i) begin
                    load_d = 1'b0;
                end else if (load_q) begin
                    load_d = 1'b0;
                    if (dvs_q == ZeroWord) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        cnt_d   = 6'd0;
                        w_d     = {ZeroWord, dvd_q, 1'b0};
                    end
                end else if (start_i == DivStart) begin
                    load_d     = 1'b1;
                    dvd_d      = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                    dvs_d      = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                    neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i & opdata1_i[31];
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == 6'd32) begin
                    state_d  = DivEnd;
                    result_d = {rem, quot};
                    ready_d  = DivResultReady;
                end else begin
                    // Keep the partial remainder when the trial subtraction borrows.
                    w_d   = diff[32] ? {w_q[63:0], 1'b0} : {diff[31:0], w_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            w_q        <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            load_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            load_q     <= load_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
